// File: rtl/regfile_dump_pkg.sv
// Shared types and sizes for the register-file dump engine.
package regfile_dump_pkg;

  localparam int unsigned NREG  = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {IDLE, SCAN, SEND, FIN} dump_state_t;

endpackage

// File: rtl/regfile_dump_higher_set.sv
// Flags whether any mask bit strictly above idx is set; a clear result marks the last word.
module regfile_dump_higher_set
  import regfile_dump_pkg::*;
(
  input  logic [NREG-1:0]  mask,
  input  logic [IDX_W-1:0] idx,
  output logic             any_above
);

  logic [NREG-1:0] above_mask;

  always_comb begin
    // 2<<idx minus one covers bits 0..idx; at idx=7 the shift overflows to zero, so nothing is above.
    above_mask = ~((NREG'(2) << idx) - NREG'(1));
    any_above  = |(mask & above_mask);
  end

endmodule

// File: rtl/regfile_dump.sv
// Walks register indices 0..7, captures masked registers and streams them out over valid/ready.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [NREG-1:0]  mask,
  output logic [IDX_W-1:0] rd_sel,
  input  logic [W-1:0]     rd_data,
  output logic [W-1:0]     out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  dump_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NREG-1:0]  mask_q, mask_d;
  logic [W-1:0]     data_q, data_d;
  logic [IDX_W-1:0] oidx_q, oidx_d;
  logic             last_q, last_d;
  logic             any_above;

  regfile_dump_higher_set u_higher_set (
    .mask      (mask_q),
    .idx       (idx_q),
    .any_above (any_above)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      oidx_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      oidx_q  <= oidx_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    data_d  = data_q;
    oidx_d  = oidx_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          mask_d  = mask;
          idx_d   = '0;
          state_d = (mask == '0) ? FIN : SCAN;
        end
      end
      SCAN: begin
        if (mask_q[idx_q]) begin
          data_d  = rd_data;
          oidx_d  = idx_q;
          last_d  = ~any_above;
          state_d = SEND;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SEND: begin
        if (out_ready) begin
          last_d = 1'b0;
          if (last_q) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = SCAN;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides whatever the state decided; no done pulse follows.
    if (abort) begin
      state_d = IDLE;
      last_d  = 1'b0;
    end
  end

  assign rd_sel    = (state_q == SCAN) ? idx_q : '0;
  assign out_data  = data_q;
  assign out_idx   = oidx_q;
  assign out_last  = last_q;
  assign out_valid = (state_q == SEND);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);

endmodule

// File: tb/tb_regfile_dump.sv
// Directed self-checking bench for regfile_dump with a small register-file model.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  mask;
  logic [2:0]  rd_sel;
  logic [15:0] rd_data;
  logic [15:0] out_data;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  logic [15:0] regs [8];
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;

  int checks   = 0;
  int failures = 0;

  logic [15:0] w_data [16];
  logic [2:0]  w_idx  [16];
  logic        w_last [16];
  int          w_cyc  [16];
  int          nw, ndone, done_cyc;

  regfile_dump #(.W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .mask      (mask),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_en) regs[wr_addr] <= wr_data;
  assign rd_data = regs[rd_sel];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Cycle c counts negedges after the one where start was raised.
  task automatic run_dump(input logic [7:0] m, input int restart_c, input int maxc);
    int c;
    nw = 0; ndone = 0; done_cyc = -1;
    @(negedge clk);
    mask = m; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mask  = ~m;
    c = 1;
    while (c < maxc) begin
      start = (c == restart_c);
      if (c == restart_c) mask = 8'hFF;
      if (out_valid && out_ready && nw < 16) begin
        w_data[nw] = out_data; w_idx[nw] = out_idx; w_last[nw] = out_last; w_cyc[nw] = c;
        nw++;
      end
      if (done) begin ndone++; done_cyc = c; end
      if (!busy && c > 1) break;
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    check("dump_finished", 32'(busy), 32'(0));
  endtask

  initial begin
    int c;
    reset = 1'b0; start = 1'b0; abort = 1'b0; mask = 8'h00; out_ready = 1'b0;
    wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0;
    #12;
    check("rst_busy",     32'(busy),      32'(0));
    check("rst_valid",    32'(out_valid), 32'(0));
    check("rst_done",     32'(done),      32'(0));
    check("rst_rd_sel",   32'(rd_sel),    32'(0));
    check("rst_out_data", 32'(out_data),  32'(0));
    check("rst_out_idx",  32'(out_idx),   32'(0));
    check("rst_out_last", 32'(out_last),  32'(0));
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) wr(3'(i), 16'h1000 + 16'(i));

    // Full dump, one word every two cycles starting at cycle 2.
    run_dump(8'hFF, -1, 40);
    check("full_nw", 32'(nw), 32'(8));
    for (int k = 0; k < 8; k++) begin
      check($sformatf("full_idx%0d", k),  32'(w_idx[k]),  32'(k));
      check($sformatf("full_data%0d", k), 32'(w_data[k]), 32'(16'h1000 + 16'(k)));
      check($sformatf("full_last%0d", k), 32'(w_last[k]), 32'(k == 7));
      check($sformatf("full_cyc%0d", k),  32'(w_cyc[k]),  32'(2 + 2 * k));
    end
    check("full_ndone",   32'(ndone),    32'(1));
    check("full_donecyc", 32'(done_cyc), 32'(17));

    // Sparse mask, with a restart attempt mid-dump that must be ignored.
    wr(3'd2, 16'hBEEF);
    wr(3'd5, 16'hCAFE);
    wr(3'd7, 16'h0042);
    run_dump(8'b1010_0100, 5, 40);
    check("sparse_nw", 32'(nw), 32'(3));
    check("sparse_idx0",  32'(w_idx[0]),  32'(2));
    check("sparse_data0", 32'(w_data[0]), 32'(16'hBEEF));
    check("sparse_last0", 32'(w_last[0]), 32'(0));
    check("sparse_cyc0",  32'(w_cyc[0]),  32'(4));
    check("sparse_idx1",  32'(w_idx[1]),  32'(5));
    check("sparse_data1", 32'(w_data[1]), 32'(16'hCAFE));
    check("sparse_last1", 32'(w_last[1]), 32'(0));
    check("sparse_cyc1",  32'(w_cyc[1]),  32'(8));
    check("sparse_idx2",  32'(w_idx[2]),  32'(7));
    check("sparse_data2", 32'(w_data[2]), 32'(16'h0042));
    check("sparse_last2", 32'(w_last[2]), 32'(1));
    check("sparse_cyc2",  32'(w_cyc[2]),  32'(11));
    check("sparse_ndone",   32'(ndone),    32'(1));
    check("sparse_donecyc", 32'(done_cyc), 32'(12));

    // Empty mask goes straight to FIN.
    run_dump(8'h00, -1, 10);
    check("empty_nw",      32'(nw),       32'(0));
    check("empty_ndone",   32'(ndone),    32'(1));
    check("empty_donecyc", 32'(done_cyc), 32'(1));

    // Backpressure: the R0 word is held for five stalled cycles.
    @(negedge clk);
    mask = 8'h03; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("bp_c1_busy",  32'(busy),      32'(1));
    check("bp_c1_valid", 32'(out_valid), 32'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'(1));
      check($sformatf("bp_hold_data%0d", i),  32'(out_data),  32'(16'h1000));
      check($sformatf("bp_hold_idx%0d", i),   32'(out_idx),   32'(0));
      check($sformatf("bp_hold_last%0d", i),  32'(out_last),  32'(0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    check("bp_c7_valid", 32'(out_valid), 32'(1));
    check("bp_c7_data",  32'(out_data),  32'(16'h1000));
    @(negedge clk);
    check("bp_c8_valid",  32'(out_valid), 32'(0));
    check("bp_c8_rd_sel", 32'(rd_sel),    32'(1));
    @(negedge clk);
    check("bp_c9_valid", 32'(out_valid), 32'(1));
    check("bp_c9_data",  32'(out_data),  32'(16'h1001));
    check("bp_c9_idx",   32'(out_idx),   32'(1));
    check("bp_c9_last",  32'(out_last),  32'(1));
    @(negedge clk);
    check("bp_c10_done",  32'(done),      32'(1));
    check("bp_c10_valid", 32'(out_valid), 32'(0));
    @(negedge clk);
    check("bp_c11_done", 32'(done), 32'(0));
    check("bp_c11_busy", 32'(busy), 32'(0));

    // Abort while idx 3 is on offer.
    @(negedge clk);
    mask = 8'hFF; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 2; i <= 8; i++) @(negedge clk);
    check("abort_pre_valid", 32'(out_valid), 32'(1));
    check("abort_pre_idx",   32'(out_idx),   32'(3));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy",  32'(busy),      32'(0));
    check("abort_valid", 32'(out_valid), 32'(0));
    check("abort_last",  32'(out_last),  32'(0));
    c = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) c++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(c), 32'(0));

    // Asynchronous reset mid-SCAN clears outputs without waiting for a clock edge.
    @(negedge clk);
    mask = 8'h80; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rscan_rd_sel", 32'(rd_sel),   32'(2));
    check("rscan_busy",   32'(busy),     32'(1));
    check("rscan_data",   32'(out_data), 32'(16'h1003));
    #2 reset = 1'b0;
    #1;
    check("arst_busy",     32'(busy),      32'(0));
    check("arst_rd_sel",   32'(rd_sel),    32'(0));
    check("arst_out_data", 32'(out_data),  32'(0));
    check("arst_out_idx",  32'(out_idx),   32'(0));
    check("arst_valid",    32'(out_valid), 32'(0));
    check("arst_last",     32'(out_last),  32'(0));
    check("arst_done",     32'(done),      32'(0));
    @(negedge clk);
    reset = 1'b1;
    run_dump(8'h01, -1, 10);
    check("post_rst_nw",      32'(nw),        32'(1));
    check("post_rst_idx",     32'(w_idx[0]),  32'(0));
    check("post_rst_data",    32'(w_data[0]), 32'(16'h1000));
    check("post_rst_last",    32'(w_last[0]), 32'(1));
    check("post_rst_donecyc", 32'(done_cyc),  32'(3));

    // CPU write on the capture edge: the old value is emitted.
    wr(3'd4, 16'hAAAA);
    @(negedge clk);
    mask = 8'h10; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 2; i <= 5; i++) @(negedge clk);
    check("coll_rd_sel", 32'(rd_sel), 32'(4));
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h5555;
    @(negedge clk);
    wr_en = 1'b0;
    check("coll_valid", 32'(out_valid), 32'(1));
    check("coll_idx",   32'(out_idx),   32'(4));
    check("coll_data",  32'(out_data),  32'(16'hAAAA));
    check("coll_last",  32'(out_last),  32'(1));
    out_ready = 1'b1;
    @(negedge clk);
    check("coll_done", 32'(done), 32'(1));
    @(negedge clk);
    check("coll_idle", 32'(busy), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
